// File: rtl/tt_sweep_controller.sv
// Exhaustive truth-table sweep of a 4-input, 1-output combinational network:
// drives all 16 minterms, samples the output, and checks it against an expected code.
module tt_sweep_controller #(
   parameter int SETTLE_CYCLES = 8,
   parameter int NUM_SAMPLES   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] expected,
   output logic        in1,
   output logic        in2,
   output logic        in3,
   output logic        in4,
   input  logic        dut_out,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] captured,
   output logic [15:0] mismatch,
   output logic [15:0] unstable,
   output logic [4:0]  err_count
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || NUM_SAMPLES < 1 || NUM_SAMPLES > 15) begin : g_param_check
      $error("tt_sweep_controller: SETTLE_CYCLES must be 1..255 and NUM_SAMPLES 1..15");
   end

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] SAMPLE_LAST = 4'(NUM_SAMPLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_ADVANCE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t      state_reg;
   logic [3:0]  m_reg;
   logic [7:0]  settle_cnt_reg;
   logic [3:0]  sample_cnt_reg;
   logic        ref_reg;
   logic [15:0] expected_reg;
   logic [15:0] mismatch_next;
   logic [4:0]  err_count_next;
   logic        active;

   // An unstable minterm counts as an error even if its reference sample matched.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_mismatch
         assign mismatch_next[gi] = (captured[gi] ^ expected_reg[gi]) | unstable[gi];
      end
   endgenerate

   always_comb begin
      err_count_next = 5'd0;
      for (int i = 0; i < 16; i++) begin
         err_count_next = err_count_next + 5'(mismatch_next[i]);
      end
   end

   assign active = (state_reg != S_IDLE) && (state_reg != S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         m_reg          <= 4'd0;
         settle_cnt_reg <= 8'd0;
         sample_cnt_reg <= 4'd0;
         ref_reg        <= 1'b0;
         expected_reg   <= 16'h0;
         {in1, in2, in3, in4} <= 4'b0000;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         captured       <= 16'h0;
         mismatch       <= 16'h0;
         unstable       <= 16'h0;
         err_count      <= 5'd0;
      end else if (abort && active) begin
         // Partial captured/unstable contents are left in place for inspection.
         state_reg      <= S_IDLE;
         {in1, in2, in3, in4} <= 4'b0000;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start) begin
                  expected_reg <= expected;
                  m_reg        <= 4'd0;
                  captured     <= 16'h0;
                  unstable     <= 16'h0;
                  mismatch     <= 16'h0;
                  err_count    <= 5'd0;
                  done         <= 1'b0;
                  pass         <= 1'b0;
                  busy         <= 1'b1;
                  state_reg    <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               {in1, in2, in3, in4} <= m_reg;
               settle_cnt_reg <= 8'd0;
               state_reg      <= S_SETTLE;
            end
            S_SETTLE: begin
               if (settle_cnt_reg == SETTLE_LAST) begin
                  sample_cnt_reg <= 4'd0;
                  state_reg      <= S_SAMPLE;
               end else begin
                  settle_cnt_reg <= settle_cnt_reg + 8'd1;
               end
            end
            S_SAMPLE: begin
               if (sample_cnt_reg == 4'd0) begin
                  ref_reg         <= dut_out;
                  captured[m_reg] <= dut_out;
               end else if (dut_out != ref_reg) begin
                  unstable[m_reg] <= 1'b1;
               end
               if (sample_cnt_reg == SAMPLE_LAST) begin
                  state_reg <= S_ADVANCE;
               end else begin
                  sample_cnt_reg <= sample_cnt_reg + 4'd1;
               end
            end
            S_ADVANCE: begin
               if (m_reg == 4'd15) begin
                  state_reg <= S_COMPARE;
               end else begin
                  m_reg     <= m_reg + 4'd1;
                  state_reg <= S_DRIVE;
               end
            end
            S_COMPARE: begin
               mismatch  <= mismatch_next;
               err_count <= err_count_next;
               pass      <= (mismatch_next == 16'h0);
               done      <= 1'b1;
               busy      <= 1'b0;
               state_reg <= S_DONE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_sweep_controller.sv
// Bench for tt_sweep_controller: stub networks drive dut_out, a queue of
// predicted sweep results is popped and compared when done rises.
module tb_tt_sweep_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] expected;
   logic        in1, in2, in3, in4;
   logic        dut_out;
   logic        busy, done, pass;
   logic [15:0] captured, mismatch, unstable;
   logic [4:0]  err_count;

   logic        tog = 1'b0;
   int          stub_mode = 0;   // 0: in1&in2, 1: xor of all, 2: toggles at m==5
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic [15:0] cap;
      logic [15:0] cap_mask;
      logic [15:0] mis;
      logic [15:0] uns;
      logic [4:0]  errs;
      logic        pass_v;
   } exp_t;

   exp_t sb_q[$];

   tt_sweep_controller dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4), .dut_out(dut_out),
      .busy(busy), .done(done), .pass(pass), .captured(captured),
      .mismatch(mismatch), .unstable(unstable), .err_count(err_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) tog <= ~tog;

   function automatic logic stub_f(int mode, logic [3:0] m, logic t);
      case (mode)
         0:       return m[3] & m[2];
         1:       return ^m;
         default: return (m == 4'd5) ? t : 1'b0;
      endcase
   endfunction

   assign dut_out = stub_f(stub_mode, {in1, in2, in3, in4}, tog);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t predict(int mode, logic [15:0] exp_v);
      exp_t e;
      e.cap = 16'h0;
      e.cap_mask = 16'hFFFF;
      e.uns = 16'h0;
      for (int m = 0; m < 16; m++) begin
         e.cap[m] = stub_f(mode, 4'(m), 1'b0);
         if (mode == 2 && m == 5) begin
            e.uns[m] = 1'b1;
            e.cap_mask[m] = 1'b0;
         end
      end
      e.mis = (e.cap ^ exp_v) | e.uns;
      e.errs = 5'($countones(e.mis));
      e.pass_v = (e.mis == 16'h0);
      return e;
   endfunction

   task automatic run_sweep(input int mode, input logic [15:0] exp_v, input bit inject_start);
      int   cycles;
      bit   busy_low;
      exp_t e;
      stub_mode = mode;
      sb_q.push_back(predict(mode, exp_v));
      expected = exp_v;
      start = 1'b1;
      tick();
      start = 1'b0;
      cycles = 0;
      busy_low = 1'b0;
      while (!done && cycles < 1000) begin
         if (!busy) busy_low = 1'b1;
         if (inject_start && cycles == 50) begin
            start = 1'b1;
            expected = 16'h0000;
         end else begin
            start = 1'b0;
         end
         tick();
         cycles++;
      end
      start = 1'b0;
      chk("busy_hold", 32'(busy_low), 32'd0);
      chk("latency", cycles, 32'd209);
      e = sb_q.pop_front();
      if (done) begin
         chk("captured", 32'(captured & e.cap_mask), 32'(e.cap & e.cap_mask));
         chk("mismatch", 32'(mismatch), 32'(e.mis));
         chk("unstable", 32'(unstable), 32'(e.uns));
         chk("err_count", 32'(err_count), 32'(e.errs));
         chk("pass", 32'(pass), 32'(e.pass_v));
         chk("busy_done", 32'(busy), 32'd0);
      end else begin
         chk("done_timeout", 32'(done), 32'd1);
      end
      $display("sweep mode=%0d exp=%04h cycles=%0d cap=%04h mis=%04h uns=%04h err=%0d pass=%0b",
               mode, exp_v, cycles, captured, mismatch, unstable, err_count, pass);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ins"}, 32'({in1, in2, in3, in4}), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_captured"}, 32'(captured), 32'd0);
      chk({tag, "_mismatch"}, 32'(mismatch), 32'd0);
      chk({tag, "_unstable"}, 32'(unstable), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running want=finished");
      $fatal(1, "simulation timeout");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      expected = 16'h0;
      repeat (3) tick();
      check_reset_vals("reset");
      rst = 1'b0;
      tick();

      run_sweep(0, 16'hF000, 1'b0);
      run_sweep(0, 16'hF001, 1'b0);
      run_sweep(1, 16'h6996, 1'b0);
      // Restart from DONE; a start pulse mid-sweep must be ignored.
      run_sweep(1, 16'h9669, 1'b1);
      run_sweep(2, 16'h0000, 1'b0);

      // Abort 40 cycles in, with start held in the same cycle.
      stub_mode = 0;
      expected = 16'hF000;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (40) tick();
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_ins", 32'({in1, in2, in3, in4}), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      $display("abort applied busy=%0b done=%0b", busy, done);
      tick();
      run_sweep(0, 16'hF000, 1'b0);

      // Reset during SAMPLE of minterm 0 with start held high.
      stub_mode = 1;
      expected = 16'h6996;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      start = 1'b1;
      tick();
      check_reset_vals("midrst");
      rst = 1'b0;
      start = 1'b0;
      repeat (5) tick();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
      $display("reset applied busy=%0b done=%0b", busy, done);
      run_sweep(1, 16'h6996, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
